// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 bicolour LED matrix scan logic.
// Slot encoding is {line, color}; color 0 = red, 1 = green.
package led_matrix_pkg;

  localparam int LINES  = 8;
  localparam int COLS   = 8;
  localparam int COLORS = 2;

  typedef enum logic [1:0] {
    SHIFT,
    LATCH,
    DISPLAY
  } scan_state_e;

  typedef logic [COLORS-1:0][LINES-1:0][COLS-1:0] frame_t;

  function automatic logic [2:0] slot_line(input logic [3:0] slot);
    return slot[3:1];
  endfunction

  function automatic logic slot_color(input logic [3:0] slot);
    return slot[0];
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks.
// The tick is asserted while the counter sits at its terminal value.
module led_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Double-buffered scan controller: shifts, latches and lights one
// line/colour slot at a time; buffers swap only at the frame boundary.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int DWELL_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic       wr_color,
  input  logic [2:0] wr_line,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic       sr_data,
  output logic       sr_clk,
  output logic       sr_latch,
  output logic [2:0] line_sel,
  output logic       col_red_n,
  output logic       col_green_n
);

  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS + 1) : 1;

  logic tick;

  led_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  scan_state_e state_q, state_d;
  logic [3:0]    slot_q, slot_d;
  logic [3:0]    sh_cnt_q, sh_cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          front_q, front_d;

  logic       sr_data_d, sr_clk_d, sr_latch_d;
  logic [2:0] line_sel_d;
  logic       red_n_d, green_n_d;
  logic       swap_ack_d, frame_start_d;

  frame_t buf_q [2];
  frame_t front_frame;
  logic   px;

  // Host writes always land in whichever buffer is not being shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (wr_en) begin
      buf_q[~front_q][wr_color][wr_line] <= wr_data;
    end
  end

  assign front_frame = buf_q[front_q];
  assign px = front_frame[slot_color(slot_q)][slot_line(slot_q)][~sh_cnt_q[3:1]];

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    sh_cnt_d      = sh_cnt_q;
    dwell_d       = dwell_q;
    front_d       = front_q;
    sr_data_d     = sr_data;
    sr_clk_d      = sr_clk;
    sr_latch_d    = sr_latch;
    line_sel_d    = line_sel;
    red_n_d       = col_red_n;
    green_n_d     = col_green_n;
    swap_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        SHIFT: begin
          red_n_d   = 1'b1;
          green_n_d = 1'b1;
          if (!sh_cnt_q[0]) begin
            sr_data_d     = px;
            sr_clk_d      = 1'b0;
            frame_start_d = (slot_q == 4'd0) && (sh_cnt_q == 4'd0);
          end else begin
            sr_clk_d = 1'b1;
          end
          sh_cnt_d = sh_cnt_q + 4'd1;
          if (sh_cnt_q == 4'd15) begin
            state_d = LATCH;
          end
        end
        LATCH: begin
          sr_clk_d   = 1'b0;
          sr_latch_d = 1'b1;
          dwell_d    = '0;
          state_d    = DISPLAY;
        end
        DISPLAY: begin
          sr_latch_d = 1'b0;
          line_sel_d = slot_line(slot_q);
          red_n_d    = slot_color(slot_q);
          green_n_d  = ~slot_color(slot_q);
          dwell_d    = dwell_q + 1'b1;
          if (dwell_q == DW'(DWELL_TICKS - 1)) begin
            state_d = SHIFT;
            slot_d  = slot_q + 4'd1;
            // Frame boundary: the only point a swap may be taken.
            if (slot_q == 4'd15 && swap_req) begin
              front_d    = ~front_q;
              swap_ack_d = 1'b1;
            end
          end
        end
        default: state_d = SHIFT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHIFT;
      slot_q      <= '0;
      sh_cnt_q    <= '0;
      dwell_q     <= '0;
      front_q     <= 1'b0;
      sr_data     <= 1'b0;
      sr_clk      <= 1'b0;
      sr_latch    <= 1'b0;
      line_sel    <= '0;
      col_red_n   <= 1'b1;
      col_green_n <= 1'b1;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      sh_cnt_q    <= sh_cnt_d;
      dwell_q     <= dwell_d;
      front_q     <= front_d;
      sr_data     <= sr_data_d;
      sr_clk      <= sr_clk_d;
      sr_latch    <= sr_latch_d;
      line_sel    <= line_sel_d;
      col_red_n   <= red_n_d;
      col_green_n <= green_n_d;
      swap_ack    <= swap_ack_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl with CLK_DIV=2, DWELL_TICKS=4.
// A negedge monitor reconstructs each frame; the main sequence checks it.
module tb_led_matrix_scan_ctrl;

  localparam int CLK_DIV = 2;
  localparam int DWELL   = 4;
  localparam int FRAME   = 16 * (16 + 1 + DWELL) * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_color = 1'b0;
  logic [2:0] wr_line = '0;
  logic [7:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_start, sr_data, sr_clk, sr_latch;
  logic [2:0] line_sel;
  logic       col_red_n, col_green_n;

  led_matrix_scan_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .DWELL_TICKS(DWELL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_color   (wr_color),
    .wr_line    (wr_line),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .frame_start(frame_start),
    .sr_data    (sr_data),
    .sr_clk     (sr_clk),
    .sr_latch   (sr_latch),
    .line_sel   (line_sel),
    .col_red_n  (col_red_n),
    .col_green_n(col_green_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] idle_vec;
  assign idle_vec = {sr_data, sr_clk, sr_latch, line_sel,
                     col_red_n, col_green_n, swap_ack, frame_start};
  localparam logic [9:0] IDLE = 10'b000_000_11_00;

  logic       sclk_p = 1'b0;
  logic       slat_p = 1'b0;
  logic [7:0] shreg = '0;
  logic [3:0] lat_idx = '0;
  logic [3:0] dslot;
  logic [7:0] lat_val [16];
  logic [7:0] prev_lat [16];
  logic [2:0] disp_line [16];
  logic [2:0] prev_line [16];
  logic [1:0] disp_en [16];
  logic [1:0] prev_en [16];
  int         disp_cyc [16];
  int         prev_cyc [16];
  int         nbits = 0;
  int         prev_nbits = 0;
  int         ack_cnt = 0;
  int         ack_cyc = 0;
  int         viol = 0;

  assign dslot = lat_idx - 4'd1;

  always @(negedge clk) begin
    sclk_p <= sr_clk;
    slat_p <= sr_latch;
    if (sr_clk && !sclk_p) begin
      shreg <= {shreg[6:0], sr_data};
      nbits <= nbits + 1;
    end
    if (sr_latch && !slat_p) begin
      lat_val[lat_idx] <= shreg;
      lat_idx <= lat_idx + 4'd1;
    end
    if (!col_red_n || !col_green_n) begin
      disp_line[dslot] <= line_sel;
      disp_en[dslot]   <= {col_red_n, col_green_n};
      disp_cyc[dslot]  <= disp_cyc[dslot] + 1;
    end
    if (frame_start) begin
      prev_lat   <= lat_val;
      prev_line  <= disp_line;
      prev_en    <= disp_en;
      prev_cyc   <= disp_cyc;
      prev_nbits <= nbits;
      lat_val    <= '{default: '0};
      disp_line  <= '{default: '0};
      disp_en    <= '{default: 2'b11};
      disp_cyc   <= '{default: 0};
      nbits      <= 0;
      lat_idx    <= '0;
    end
    if (swap_ack) begin
      ack_cnt <= ack_cnt + 1;
      ack_cyc <= cyc;
    end
    if (!col_red_n && !col_green_n) viol <= viol + 1;
    if ((sr_clk || sr_latch) && !(col_red_n && col_green_n)) viol <= viol + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int fs_cyc = 0;
  int fs_wait = 0;
  int t0 = 0;

  task automatic wait_fs(input string tag);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < FRAME + 50) begin
      @(negedge clk);
      n++;
      if (frame_start) seen = 1'b1;
    end
    fs_wait = n;
    fs_cyc  = cyc;
    chk(tag, seen, 1'b1);
    #1;
  endtask

  task automatic wr(input logic c, input logic [2:0] l, input logic [7:0] d);
    wr_en    = 1'b1;
    wr_color = c;
    wr_line  = l;
    wr_data  = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    bit found;
    int nz;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_idle", idle_vec, IDLE);
    rst_n = 1'b1;

    wait_fs("fs0_seen");
    chk("fs0_latency", fs_wait, 2);
    chk("ack_none_yet", ack_cnt, 0);
    t0 = fs_cyc;
    wr(1'b0, 3'd3, 8'hA5);
    wr(1'b1, 3'd7, 8'hFF);
    swap_req = 1'b1;

    wait_fs("fs1_seen");
    swap_req = 1'b0;
    chk("period_0", fs_cyc - t0, FRAME);
    chk("swap_one", ack_cnt, 1);
    chk("swap_align_1", fs_cyc - ack_cyc, 2);
    chk("f0_old_front", prev_lat[6], 8'h00);
    chk("f0_bits", prev_nbits, 128);
    t0 = fs_cyc;

    wait_fs("fs2_seen");
    chk("period_1", fs_cyc - t0, FRAME);
    chk("f1_lat6", prev_lat[6], 8'hA5);
    chk("f1_line6", prev_line[6], 3'd3);
    chk("f1_en6", prev_en[6], 2'b01);
    chk("f1_dwell6", prev_cyc[6], DWELL * CLK_DIV);
    chk("f1_lat7", prev_lat[7], 8'h00);
    chk("f1_lat14", prev_lat[14], 8'h00);
    chk("f1_lat15", prev_lat[15], 8'hFF);
    chk("f1_line15", prev_line[15], 3'd7);
    chk("f1_en15", prev_en[15], 2'b10);
    chk("f1_dwell15", prev_cyc[15], DWELL * CLK_DIV);

    wr(1'b0, 3'd3, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      wait_fs("fs_hold_seen");
      chk("hold_lat6", prev_lat[6], 8'hA5);
      chk("hold_no_swap", ack_cnt, 1);
    end

    swap_req = 1'b1;
    wait_fs("fs_s1_seen");
    chk("held_swap_1", ack_cnt, 2);
    chk("held_align_1", fs_cyc - ack_cyc, 2);
    chk("held_prev_a5", prev_lat[6], 8'hA5);
    wait_fs("fs_s2_seen");
    chk("held_swap_2", ack_cnt, 3);
    chk("held_align_2", fs_cyc - ack_cyc, 2);
    chk("back_lat6", prev_lat[6], 8'h3C);
    chk("back_lat15", prev_lat[15], 8'h00);

    repeat (FRAME - 3) @(negedge clk);
    wr_en    = 1'b1;
    wr_color = 1'b0;
    wr_line  = 3'd0;
    wr_data  = 8'h81;
    @(negedge clk);
    wr_en    = 1'b0;
    swap_req = 1'b0;
    chk("swap_cycle_ack", swap_ack, 1'b1);

    wait_fs("fs_s3_seen");
    chk("held_swap_3", ack_cnt, 4);
    chk("pre_wr_lat0", prev_lat[0], 8'h00);
    chk("pre_wr_lat6", prev_lat[6], 8'hA5);
    wait_fs("fs_s4_seen");
    chk("released_no_swap", ack_cnt, 4);
    chk("same_cyc_wr_lat0", prev_lat[0], 8'h81);
    chk("same_cyc_wr_lat6", prev_lat[6], 8'h3C);

    found = 1'b0;
    for (int n = 0; n < FRAME && !found; n++) begin
      @(negedge clk);
      if (lat_idx == 4'd10 && !col_green_n && line_sel == 3'd4) found = 1'b1;
    end
    chk("slot9_display", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_idle", idle_vec, IDLE);
    repeat (2) @(negedge clk);
    chk("reset_hold_idle", idle_vec, IDLE);
    rst_n = 1'b1;

    wait_fs("fs_rst_seen");
    chk("fs_rst_latency", fs_wait, 2);
    wait_fs("fs_rst2_seen");
    nz = 0;
    for (int s = 0; s < 16; s++) if (prev_lat[s] != 8'h00) nz++;
    chk("cleared_buffers", nz, 0);
    chk("cleared_bits", prev_nbits, 128);
    chk("enable_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
